// File: rtl/rf_pkg.sv
// Shared constants and types for the register file with write-back scoreboard.
package rf_pkg;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: stored value/busy with write-through bypass.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int          ZERO_R0 = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              stored_busy,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_acc,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] bus,
  output logic              busy
);

  logic is_zero;
  logic wb_hit;
  logic issue_hit;

  always_comb begin
    is_zero   = (ZERO_R0 != 0) && (addr == '0);
    wb_hit    = wb_valid && (wb_rd == addr);
    issue_hit = issue_acc && (issue_rd == addr);
    bus       = stored_data;
    busy      = stored_busy;
    if (is_zero) begin
      bus  = '0;
      busy = 1'b0;
    end else begin
      if (wb_hit) bus = wb_data;
      // A same-cycle accepted issue keeps the register busy despite the writeback.
      if (wb_hit && !issue_hit) busy = 1'b0;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with per-register pending-write tracking and WAW issue stall.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int          ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_stall,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic issue_acc, issue_set, wb_en, cnt_inc, cnt_dec;

  always_comb begin
    issue_stall = issue_valid && busy_q[issue_rd] && !(wb_valid && (wb_rd == issue_rd));
    issue_acc   = issue_valid && !issue_stall;
    issue_set   = issue_acc && !((ZERO_R0 != 0) && (issue_rd == '0));
    wb_en       = wb_valid && !((ZERO_R0 != 0) && (wb_rd == '0));

    // Count from transitions: an accepted issue on a busy register always
    // coincides with its own writeback, so busy stays set and the count holds.
    cnt_inc = issue_set && !busy_q[issue_rd];
    cnt_dec = wb_en && busy_q[wb_rd] && !(issue_set && (issue_rd == wb_rd));

    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_en) begin
      regs_d[wb_rd] = wb_data;
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_set) busy_d[issue_rd] = 1'b1;

    busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_port_a (
    .addr        (ra),
    .stored_data (regs_q[ra]),
    .stored_busy (busy_q[ra]),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .issue_acc   (issue_acc),
    .issue_rd    (issue_rd),
    .bus         (bus_a),
    .busy        (busy_a)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_port_b (
    .addr        (rb),
    .stored_data (regs_q[rb]),
    .stored_busy (busy_q[rb]),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .issue_acc   (issue_acc),
    .issue_rd    (issue_rd),
    .bus         (bus_b),
    .busy        (busy_b)
  );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: default-parameter instance plus a small ZERO_R0=0 instance.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra, rb, issue_rd, wb_rd;
  logic [31:0] bus_a, bus_b, wb_data;
  logic        busy_a, busy_b, issue_valid, issue_stall, wb_valid;
  logic [5:0]  busy_cnt;

  logic        s_rst;
  logic [2:0]  s_ra, s_rb, s_issue_rd, s_wb_rd;
  logic [15:0] s_bus_a, s_bus_b, s_wb_data;
  logic        s_busy_a, s_busy_b, s_issue_valid, s_issue_stall, s_wb_valid;
  logic [3:0]  s_busy_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rf_scoreboard dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .bus_a(bus_a), .bus_b(bus_b),
    .busy_a(busy_a), .busy_b(busy_b), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_stall(issue_stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_cnt(busy_cnt)
  );

  rf_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) dut_s (
    .clk(clk), .rst(s_rst), .ra(s_ra), .rb(s_rb), .bus_a(s_bus_a), .bus_b(s_bus_b),
    .busy_a(s_busy_a), .busy_b(s_busy_b), .issue_valid(s_issue_valid), .issue_rd(s_issue_rd),
    .issue_stall(s_issue_stall), .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
    .busy_cnt(s_busy_cnt)
  );

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_underflow: observed %0h with no expected entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; wb_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ra = '0; rb = '0; issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    s_rst = 1'b1; s_ra = '0; s_rb = '0; s_issue_valid = 1'b0; s_issue_rd = '0;
    s_wb_valid = 1'b0; s_wb_rd = '0; s_wb_data = '0;
    tick();
    // reset cycle with writeback/issue that must be ignored
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_rd = 5'd6;
    push("rst_cnt", 32'd0); push("rst_r5", 32'd0); push("rst_busy6", 32'd0);
    tick();
    rst = 1'b0; idle(); ra = 5'd5; rb = 5'd6; #1;
    pop_check(32'(busy_cnt)); pop_check(bus_a); pop_check(32'(busy_b));

    // R0 ignores writes, R5 accepts
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF; ra = 5'd0;
    push("r0_bypass_blocked", 32'd0); #1; pop_check(bus_a);
    tick();
    wb_rd = 5'd5; tick();
    idle(); ra = 5'd0; rb = 5'd5;
    push("r0_read", 32'd0); push("r5_read", 32'hDEADBEEF); push("cnt_after_wr", 32'd0);
    #1; pop_check(bus_a); pop_check(bus_b); pop_check(32'(busy_cnt));

    // write-through bypass
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678; ra = 5'd7;
    push("bypass_comb", 32'h12345678); #1; pop_check(bus_a);
    tick();
    idle();
    push("bypass_persist", 32'h12345678); #1; pop_check(bus_a);

    // WAW stall
    issue_valid = 1'b1; issue_rd = 5'd3; rb = 5'd3;
    push("issue3_nostall", 32'd0); #1; pop_check(32'(issue_stall));
    tick();
    push("issue3_stall", 32'd1); push("busy_b3", 32'd1); push("cnt_one", 32'd1);
    #1; pop_check(32'(issue_stall)); pop_check(32'(busy_b)); pop_check(32'(busy_cnt));
    tick();
    idle();
    push("stalled_no_change", 32'd1); #1; pop_check(32'(busy_cnt));
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    push("busy_b3_wb_bypass", 32'd0); #1; pop_check(32'(busy_b));
    tick();
    idle();
    push("busy_b3_cleared", 32'd0); push("cnt_zero", 32'd0); push("r3_data", 32'h33);
    #1; pop_check(32'(busy_b)); pop_check(32'(busy_cnt)); pop_check(bus_b);

    // issue + writeback collision on the same register
    issue_valid = 1'b1; issue_rd = 5'd4; tick();
    issue_valid = 1'b1; issue_rd = 5'd4; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'hA5A5A5A5;
    ra = 5'd4;
    push("coll_nostall", 32'd0); push("coll_busy_comb", 32'd1);
    #1; pop_check(32'(issue_stall)); pop_check(32'(busy_a));
    tick();
    idle();
    push("coll_data", 32'hA5A5A5A5); push("coll_busy", 32'd1); push("coll_cnt", 32'd1);
    #1; pop_check(bus_a); pop_check(32'(busy_a)); pop_check(32'(busy_cnt));

    // set one register while clearing another
    issue_valid = 1'b1; issue_rd = 5'd10; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    tick();
    idle(); ra = 5'd4; rb = 5'd10;
    push("swap_cnt", 32'd1); push("swap_clr4", 32'd0); push("swap_set10", 32'd1);
    #1; pop_check(32'(busy_cnt)); pop_check(32'(busy_a)); pop_check(32'(busy_b));

    // issue to R0 is accepted and has no effect
    issue_valid = 1'b1; issue_rd = 5'd0;
    push("r0_issue_nostall", 32'd0); #1; pop_check(32'(issue_stall));
    tick();
    idle();
    push("r0_issue_cnt", 32'd1); #1; pop_check(32'(busy_cnt));

    // reset mid-operation
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99; tick();
    idle();
    for (int i = 11; i <= 14; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i); tick();
    end
    idle();
    push("five_busy", 32'd5); #1; pop_check(32'(busy_cnt));
    rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hFFFF;
    tick();
    rst = 1'b0; idle(); ra = 5'd9; rb = 5'd14;
    push("mid_rst_cnt", 32'd0); push("mid_rst_r9", 32'd0); push("mid_rst_busy14", 32'd0);
    #1; pop_check(32'(busy_cnt)); pop_check(bus_a); pop_check(32'(busy_b));
    issue_valid = 1'b1; issue_rd = 5'd2; wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h88;
    tick();
    idle(); ra = 5'd8;
    push("post_rst_cnt", 32'd1); push("post_rst_r8", 32'h88);
    #1; pop_check(32'(busy_cnt)); pop_check(bus_a);

    // ZERO_R0=0 instance: R0 is an ordinary register; count saturates at 8
    s_rst = 1'b0; s_issue_valid = 1'b1; s_issue_rd = 3'd0; tick();
    s_issue_valid = 1'b0; s_ra = 3'd0;
    push("s_r0_cnt", 32'd1); push("s_r0_busy", 32'd1);
    #1; pop_check(32'(s_busy_cnt)); pop_check(32'(s_busy_a));
    s_wb_valid = 1'b1; s_wb_rd = 3'd0; s_wb_data = 16'hBEEF;
    push("s_r0_bypass", 32'h0000BEEF); push("s_r0_busy_bypass", 32'd0);
    #1; pop_check(32'(s_bus_a)); pop_check(32'(s_busy_a));
    tick();
    s_wb_valid = 1'b0;
    push("s_r0_cnt_clr", 32'd0); push("s_r0_data", 32'h0000BEEF);
    #1; pop_check(32'(s_busy_cnt)); pop_check(32'(s_bus_a));
    for (int i = 0; i < 8; i++) begin
      s_issue_valid = 1'b1; s_issue_rd = 3'(i); tick();
    end
    s_issue_valid = 1'b0;
    push("s_full_cnt", 32'd8); #1; pop_check(32'(s_busy_cnt));
    s_issue_valid = 1'b1; s_issue_rd = 3'd5;
    push("s_full_stall", 32'd1); #1; pop_check(32'(s_issue_stall));
    tick();
    s_issue_valid = 1'b0;
    push("s_no_wrap", 32'd8); #1; pop_check(32'(s_busy_cnt));
    s_wb_valid = 1'b1; s_wb_rd = 3'd5; s_wb_data = 16'h5555; tick();
    s_wb_valid = 1'b0;
    push("s_cnt_seven", 32'd7); #1; pop_check(32'(s_busy_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count is 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_R0, default 1; when 1, register 0 reads zero, is never written and is never busy.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have ports ra, rb, input, ADDR_W, read addresses for ports A and B.
REQ-007 SHALL have ports bus_a, bus_b, output, DATA_W, read data for ports A and B.
REQ-008 SHALL have ports busy_a, busy_b, output, 1, pending-write flag of the register addressed by ra and rb.
REQ-009 SHALL have ports issue_valid (input, 1) and issue_rd (input, ADDR_W), an instruction claiming destination issue_rd.
REQ-010 SHALL have port issue_stall, output, 1, high when the issue cannot be accepted this cycle.
REQ-011 SHALL have ports wb_valid (input, 1), wb_rd (input, ADDR_W) and wb_data (input, DATA_W), the writeback port.
REQ-012 SHALL have port busy_cnt, output, ADDR_W+1, the number of registers currently busy.

Function
REQ-013 Reads SHALL be combinational and have zero latency.
REQ-014 bus_x SHALL equal wb_data when wb_valid=1 and wb_rd equals the read address (write-through bypass); otherwise it SHALL equal the stored value.
REQ-015 busy_x SHALL read 0 when a same-cycle writeback targets that address and no same-cycle accepted issue targets it; otherwise it SHALL equal busy[addr].
REQ-016 When ZERO_R0=1 and an address is 0, bus_x and busy_x SHALL be 0 regardless of bypass.
REQ-017 On a clock edge with wb_valid=1, regs[wb_rd] SHALL be set to wb_data and busy[wb_rd] SHALL be cleared; when ZERO_R0=1 and wb_rd=0, the writeback SHALL be ignored.
REQ-018 issue_stall SHALL be high only when issue_valid=1, busy[issue_rd]=1, and no same-cycle writeback to issue_rd is present (WAW protection).
REQ-019 An accepted issue (issue_valid=1 and issue_stall=0) SHALL set busy[issue_rd] on the clock edge; when ZERO_R0=1 and issue_rd=0, it SHALL be accepted and have no effect.
REQ-020 If an accepted issue and a writeback target the same register in the same cycle, the data SHALL be written and busy SHALL end set, because the issue wins.
REQ-021 A stalled issue SHALL NOT alter any state.
REQ-022 busy_cnt SHALL be registered and track the popcount of busy: +1 on a set, -1 on a clear, unchanged on a simultaneous set and clear of the same register or of two different registers.
REQ-023 busy_cnt SHALL never wrap; its maximum is 2**ADDR_W - ZERO_R0.

Reset
REQ-024 While rst=1 at a clock edge, all registers SHALL be set to 0, all busy bits to 0 and busy_cnt to 0; issue and writeback inputs in that cycle SHALL be ignored.
REQ-025 On the first edge after rst falls, the block SHALL accept issue and writeback normally; no initial blocks SHALL be relied on for reset state.

Structure
REQ-026 A shared package (rf_pkg) SHALL hold the default DATA_W/ADDR_W constants and the register-address typedef.
REQ-027 The read-port mux with bypass SHALL be one sub-module, rf_read_port, instantiated twice.

Verification
REQ-028 Reset and zero-register check: assert rst, then write 0xDEADBEEF to R0 and R5 -> bus_a(ra=0)=0; bus_a(ra=5)=0xDEADBEEF; busy_cnt=0.
REQ-029 Bypass check: drive wb_valid with wb_rd=7, wb_data=0x12345678 and ra=7 in the same cycle -> bus_a=0x12345678 combinationally, and the value persists the next cycle.
REQ-030 Scoreboard check: issue rd=3, then issue rd=3 again -> the second issue stalls; busy_b(rb=3)=1; busy_cnt=1; wb rd=3 -> busy clears and busy_cnt=0.
REQ-031 Collision check: hold busy[4], then issue rd=4 and wb rd=4 with 0xA5A5A5A5 in the same cycle -> no stall; reg4=0xA5A5A5A5; busy[4]=1; busy_cnt unchanged.
REQ-032 Reset mid-operation: with 5 registers busy, assert rst together with a wb to R9 -> all busy bits clear, R9=0, busy_cnt=0.
REQ-033 Parameter sweep: run with DATA_W=16, ADDR_W=3, ZERO_R0=0 -> R0 is writable and can be busy; busy_cnt reaches 8 with no wrap.
